// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit integer divider, signed or unsigned.
// It uses restoring division and retires one quotient bit per cycle.
// Only one operation is in flight at a time.
//
// Handshake: a transfer happens on the rising edge where val && rdy.
// divreq_rdy is high only in IDLE, and never while reset is high.
// divresp_val is high only in DONE.
// Neither rdy depends combinationally on the val of the same side.
// In DONE, divresp_msg and divresp_val stay stable until divresp_rdy.
module imuldiv_int_div_iterative (
  input  logic        clk,
  input  logic        reset,
  input  logic [64:0] divreq_msg,
  input  logic        divreq_val,
  output logic        divreq_rdy,
  output logic [63:0] divresp_msg,
  output logic        divresp_val,
  input  logic        divresp_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;

  // Operation context latched when the request is accepted
  logic        is_signed;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;
  logic [31:0] a_raw;

  // Working registers: {partial remainder, dividend/quotient bits}
  logic [63:0] rq;
  logic [31:0] divisor;
  logic [5:0]  cnt;

  // Request field decode
  logic        req_fn;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_sign_a;
  logic        req_sign_b;
  logic [31:0] req_abs_a;
  logic [31:0] req_abs_b;

  // One restoring step
  logic [32:0] upper33;
  logic [32:0] diff;
  logic [63:0] step_rq;

  // Result shaping
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [63:0] resp_next;

  assign divreq_rdy  = (state == IDLE) && !reset;
  assign divresp_val = (state == DONE);

  // Decode the request and form operand magnitudes.
  // The magnitude of 0x80000000 stays 0x80000000 and is used as unsigned.
  always_comb begin
    req_fn     = divreq_msg[64];
    req_a      = divreq_msg[63:32];
    req_b      = divreq_msg[31:0];
    req_sign_a = req_a[31] & req_fn;
    req_sign_b = req_b[31] & req_fn;
    req_abs_a  = req_sign_a ? (32'd0 - req_a) : req_a;
    req_abs_b  = req_sign_b ? (32'd0 - req_b) : req_b;
  end

  // Shift and trial subtract.
  // The bit shifted out of the top is kept as bit 32 of upper33,
  // so the compare never overflows.
  always_comb begin
    upper33 = rq[63:31];
    diff    = upper33 - {1'b0, divisor};
    if (!diff[32]) begin
      step_rq = {diff[31:0], rq[30:0], 1'b1};
    end else begin
      step_rq = {rq[62:0], 1'b0};
    end
  end

  // Sign fixup on the final step's result.
  // Divide by zero overrides the fixup.
  always_comb begin
    q_mag = step_rq[31:0];
    r_mag = step_rq[63:32];
    q_fix = (is_signed && (sign_a ^ sign_b)) ? (32'd0 - q_mag) : q_mag;
    r_fix = (is_signed && sign_a) ? (32'd0 - r_mag) : r_mag;
    if (div_zero) begin
      resp_next = {a_raw, 32'hFFFF_FFFF};
    end else begin
      resp_next = {r_fix, q_fix};
    end
  end

  // Control FSM and datapath registers.
  // The response is registered on the last CALC step.
  // It then holds until the next result, or until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      is_signed   <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      div_zero    <= 1'b0;
      a_raw       <= 32'd0;
      rq          <= 64'd0;
      divisor     <= 32'd0;
      cnt         <= 6'd0;
      divresp_msg <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (divreq_val) begin
            is_signed <= req_fn;
            sign_a    <= req_sign_a;
            sign_b    <= req_sign_b;
            div_zero  <= (req_b == 32'd0);
            a_raw     <= req_a;
            rq        <= {32'd0, req_abs_a};
            divisor   <= req_abs_b;
            cnt       <= 6'd32;
            state     <= CALC;
          end
        end
        CALC: begin
          rq  <= step_rq;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            divresp_msg <= resp_next;
            state       <= DONE;
          end
        end
        DONE: begin
          if (divresp_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Testbench for imuldiv_int_div_iterative.
// It runs directed cases and a random back-to-back stream.
// Every result is compared with an arithmetic reference model.
module tb_imuldiv_int_div_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic [64:0] divreq_msg;
  logic        divreq_val;
  logic        divreq_rdy;
  logic [63:0] divresp_msg;
  logic        divresp_val;
  logic        divresp_rdy;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];

  // stream / misc state
  int          lat;
  int          cyc;
  int          last_fire;
  int          n_sent;
  int          n_recv;
  int          spurious;
  logic        fired;
  logic        resp;
  logic [63:0] held;

  imuldiv_int_div_iterative dut (
    .clk         (clk),
    .reset       (reset),
    .divreq_msg  (divreq_msg),
    .divreq_val  (divreq_val),
    .divreq_rdy  (divreq_rdy),
    .divresp_msg (divresp_msg),
    .divresp_val (divresp_val),
    .divresp_rdy (divresp_rdy)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // reference model: plain integer arithmetic, truncating division
  function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [31:0] uq;
    logic [31:0] ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!fn) begin
      uq = a / b;
      ur = a % b;
      return {ur, uq};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver: present one request, wait for acceptance, push the expected result
  task automatic send_req(input logic fn, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    divreq_msg = {fn, a, b};
    divreq_val = 1'b1;
    while (!divreq_rdy && w < 100) begin
      tick;
      w++;
    end
    check("req_rdy", 64'(divreq_rdy), 64'd1);
    exp_q.push_back(ref_div(fn, a, b));
    tick;
    divreq_val = 1'b0;
    divreq_msg = {1'b0, $urandom, $urandom};
  endtask

  // Count cycles from the accept edge until divresp_val is seen.
  task automatic wait_resp(output int l);
    l = 1;
    while (!divresp_val && l < 200) begin
      tick;
      l++;
    end
  endtask

  task automatic directed(input string tag, input logic fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_resp);
    int l;
    divresp_rdy = 1'b1;
    send_req(fn, a, b);
    wait_resp(l);
    check({tag, "_lat"}, 64'(l), 64'd33);
    check(tag, divresp_msg, exp_resp);
    if (exp_q.size() > 0) check({tag, "_model"}, divresp_msg, exp_q.pop_front());
    tick;
    check({tag, "_rdy_next"}, 64'(divreq_rdy), 64'd1);
    check({tag, "_val_next"}, 64'(divresp_val), 64'd0);
  endtask

  initial begin
    // reset
    reset       = 1'b1;
    divreq_val  = 1'b0;
    divreq_msg  = '0;
    divresp_rdy = 1'b1;
    tick;
    tick;
    check("reset_rdy", 64'(divreq_rdy), 64'd0);
    check("reset_val", 64'(divresp_val), 64'd0);
    check("reset_msg", divresp_msg, 64'd0);
    reset = 1'b0;
    #1;
    check("post_reset_rdy", 64'(divreq_rdy), 64'd1);

    // unsigned
    directed("u_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'h0000_000E});
    directed("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
    // signed sign combinations
    directed("s_n100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    directed("s_100_n7", 1'b1, 32'd100, 32'hFFFF_FFF9, {32'h0000_0002, 32'hFFFF_FFF2});
    directed("s_n100_n7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E});
    // divide by zero and overflow
    directed("u_div0", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
    directed("s_div0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    directed("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

    // backpressure
    divresp_rdy = 1'b0;
    send_req(1'b0, 32'd1000, 32'd33);
    wait_resp(lat);
    check("bp_lat", 64'(lat), 64'd33);
    held = divresp_msg;
    check("bp_msg", divresp_msg, {32'd10, 32'd30});
    if (exp_q.size() > 0) check("bp_model", divresp_msg, exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      tick;
      check("bp_val_hold", 64'(divresp_val), 64'd1);
      check("bp_msg_hold", divresp_msg, held);
      check("bp_req_rdy", 64'(divreq_rdy), 64'd0);
    end
    divresp_rdy = 1'b1;
    tick;
    check("bp_rdy_after", 64'(divreq_rdy), 64'd1);
    check("bp_val_after", 64'(divresp_val), 64'd0);
    check("bp_msg_kept", divresp_msg, held);

    // back-to-back random stream
    cyc       = 0;
    last_fire = -1;
    n_sent    = 0;
    n_recv    = 0;
    spurious  = 0;
    exp_q.delete();
    divresp_rdy = 1'b1;
    divreq_msg  = {1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 255)};
    divreq_val  = 1'b1;
    while (n_recv < 20 && cyc < 2000) begin
      fired = divreq_val && divreq_rdy;
      resp  = divresp_val && divresp_rdy;
      if (resp) begin
        if (exp_q.size() == 0) spurious++;
        else check("stream_resp", divresp_msg, exp_q.pop_front());
        n_recv++;
      end
      if (fired) begin
        if (last_fire >= 0) check("stream_gap", 64'(cyc - last_fire), 64'd34);
        last_fire = cyc;
        exp_q.push_back(ref_div(divreq_msg[64], divreq_msg[63:32], divreq_msg[31:0]));
        n_sent++;
      end
      tick;
      cyc++;
      if (fired) begin
        if (n_sent < 20) begin
          divreq_msg[64]    = 1'($urandom_range(0, 1));
          divreq_msg[63:32] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
          case ($urandom_range(0, 4))
            0: divreq_msg[31:0] = $urandom;
            1: divreq_msg[31:0] = $urandom_range(1, 255);
            2: divreq_msg[31:0] = 32'd0;
            3: divreq_msg[31:0] = 32'd0 - 32'($urandom_range(1, 16));
            default: divreq_msg[31:0] = 32'hFFFF_FFFF;
          endcase
        end else begin
          divreq_val = 1'b0;
        end
      end
    end
    check("stream_count", 64'(n_recv), 64'd20);
    check("stream_spurious", 64'(spurious), 64'd0);

    // reset in the middle of CALC
    divresp_rdy = 1'b1;
    send_req(1'b0, 32'd5000, 32'd3);
    repeat (9) tick;
    reset = 1'b1;
    #1;
    check("mid_reset_rdy", 64'(divreq_rdy), 64'd0);
    check("mid_reset_val", 64'(divresp_val), 64'd0);
    tick;
    reset = 1'b0;
    #1;
    check("mid_reset_rdy_next", 64'(divreq_rdy), 64'd1);
    check("mid_reset_val_next", 64'(divresp_val), 64'd0);
    check("mid_reset_msg", divresp_msg, 64'd0);
    exp_q.delete();
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (divresp_val) spurious++;
    end
    check("mid_reset_no_resp", 64'(spurious), 64'd0);
    directed("after_reset", 1'b0, 32'd100, 32'd7, {32'd2, 32'h0000_000E});

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imuldiv_int_div_iterative.md
Name: imuldiv_int_div_iterative

Overview:
- Iterative 32-bit integer divider that consumes 65-bit divider request messages.
- Request format: fn at bit 64 (0 = unsigned, 1 = signed), operand a (dividend) at [63:32], operand b (divisor) at [31:0].
- Produces a 64-bit response {remainder[63:32], quotient[31:0]}.
- Sits between the pipeline's muldiv issue logic (upstream) and writeback (downstream); both sides use val/rdy handshakes.
- One transaction in flight at a time.

Parameters:
None. All widths are fixed by the request and response message formats: 65-bit request, 64-bit response.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- divreq_msg  input  65  request message: fn[64], a[63:32], b[31:0]
- divreq_val  input  1  request valid
- divreq_rdy  output  1  request ready
- divresp_msg  output  64  response message: remainder[63:32], quotient[31:0]
- divresp_val  output  1  response valid
- divresp_rdy  input  1  response ready

Behaviour:
- **Reset**
  - Reset is synchronous and active-high on clk.
  - Reset forces state IDLE; divresp_val=0; divreq_rdy=0 while reset is high; internal registers and divresp_msg=0.
  - Reset during CALC or DONE abandons the transaction. No response is ever produced for it.
- **Handshake**
  - A transfer occurs on a rising edge when val && rdy.
  - divreq_rdy = (state==IDLE) && !reset.
  - divresp_val = (state==DONE).
  - rdy never depends combinationally on the same side's val.
- **FSM**
  - IDLE -> CALC on request fire.
  - CALC -> DONE when the iteration counter reaches 0 after 32 iterations.
  - DONE -> IDLE on response fire.
  - No request is accepted in CALC or DONE.
- **Load (IDLE fire)**
  - Latch is_signed = fn.
  - Latch sign_a = a[31]&fn and sign_b = b[31]&fn.
  - Latch div_zero = (b==0) and the raw a.
  - Load 64-bit remainder/quotient register with {32'b0, |a|}; divisor register = |b|.
    - |x| is the two's-complement negation when the corresponding sign flag is set; otherwise x unchanged.
    - |0x80000000| = 0x80000000, treated as unsigned.
  - Counter = 32.
- **CALC (one restoring step per cycle)**
  - Shift the register left by 1.
  - diff = upper33 - {1'b0, divisor}, computed with 33-bit arithmetic to avoid overflow on a 32-bit upper half.
  - If diff is non-negative: the upper half takes diff[31:0] and the LSB is set to 1. Otherwise the upper half is unchanged and the LSB is 0.
  - Counter decrements.
- **Latency**
  - Request fires at the end of cycle t.
  - Cycles t+1..t+32 are CALC; divresp_val=1 from cycle t+33.
  - With divresp_rdy=1 at t+33, the response fires; divreq_rdy=1 in cycle t+34.
  - Back-to-back throughput is one operation per 34 cycles.
- **Sign fixup (applied to the value driven in DONE)**
  - quotient is negated iff sign_a ^ sign_b.
  - remainder is negated iff sign_a; the remainder takes the dividend's sign.
- **Divide by zero** overrides fixup for both fn values: quotient = 0xFFFFFFFF, remainder = raw a.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. This result arises naturally; no special case is needed.
- **Backpressure in DONE**: divresp_msg and divresp_val are held stable until divresp_rdy. DONE is held indefinitely.
- **After the response fires**: divresp_msg holds its last value. It is never X after the first transaction.

Test Plan:
1. Unsigned basic and full-width.
   - fn=0, a=0x00000064, b=0x00000007 -> response 33 cycles after accept: quotient 0x0000000E, remainder 0x00000002.
   - fn=0, a=0xFFFFFFFF, b=1 -> quotient 0xFFFFFFFF, remainder 0.
2. Signed sign combinations.
   - a=0xFFFFFF9C (-100), b=7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
   - a=100, b=0xFFFFFFF9 -> quotient 0xFFFFFFF2, remainder 0x00000002.
   - a=-100, b=-7 -> quotient 0x0000000E, remainder 0xFFFFFFFE.
3. Divide by zero and overflow.
   - fn=0, a=0x12345678, b=0 -> quotient 0xFFFFFFFF, remainder 0x12345678.
   - fn=1, a=0xFFFFFFFB, b=0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB.
   - fn=1, a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0.
4. Backpressure.
   - Hold divresp_rdy=0 for 10 cycles after divresp_val rises -> divresp_msg stable, divresp_val=1, divreq_rdy=0 throughout.
   - Raising rdy completes the transfer; divreq_rdy=1 on the next cycle.
5. Back-to-back stream of 20 random signed/unsigned requests, source always valid, sink always ready.
   - Every result matches the golden model.
   - Accepts are spaced exactly 34 cycles apart.
6. Reset mid-operation.
   - Assert reset for 1 cycle at CALC cycle 10 -> divresp_val=0 and divreq_rdy=0 during reset; divreq_rdy=1 the cycle after.
   - No response for the aborted operation; the next request (fn=0, 100/7) returns 0x0000000E / 0x00000002.
